// File: rtl/inst_encoder.sv
// Instruction packer and issue FIFO. Packs range-checked field sets into the
// processor's 64-bit instruction word and streams them out over valid/ready.
module inst_encoder #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [4:0]    in_reg1,
  input  logic [4:0]    in_reg2,
  input  logic [4:0]    in_reg3,
  input  logic [15:0]   in_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_inst,
  output logic [CW-1:0] count,
  output logic          err_reg3,
  output logic [7:0]    err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_live;
  logic          r_err_reg3;
  logic [7:0]    r_err_cnt;

  logic          w_accept;
  logic          w_reject;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;

  // r_live holds in_ready low while reset is asserted without routing rst_n into logic.
  assign in_ready  = r_live && (r_count < CW'(DEPTH)) && !flush;
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_reject  = w_accept && (in_reg3[4:3] != 2'b00);
  assign w_push    = w_accept && !w_reject;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_word    = {in_opcode, in_reg1, in_reg2, in_reg3[2:0], in_addr};

  assign out_inst  = out_valid ? {32'h0, r_mem[r_rptr]} : 64'h0;
  assign count     = r_count;
  assign err_reg3  = r_err_reg3;
  assign err_cnt   = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_live     <= 1'b0;
      r_err_reg3 <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_live     <= 1'b1;
      r_err_reg3 <= w_reject;
      if (w_reject && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  // Storage is not reset; out_inst is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_inst_encoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = '0;
  logic [4:0]    in_reg1 = '0;
  logic [4:0]    in_reg2 = '0;
  logic [4:0]    in_reg3 = '0;
  logic [15:0]   in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_inst;
  logic [CW-1:0] count;
  logic          err_reg3;
  logic [7:0]    err_cnt;

  int errors = 0;
  int checks = 0;

  longint unsigned q[$];
  int              m_err_cnt = 0;
  int              m_err_pulse = 0;

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_reg3(in_reg3), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .count(count), .err_reg3(err_reg3), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pack(int op, int r1, int r2, int r3, int addr);
    return longint'(op) * (64'd1 << 29) + longint'(r1) * (64'd1 << 24)
         + longint'(r2) * (64'd1 << 19) + longint'(r3 % 8) * (64'd1 << 16)
         + longint'(addr);
  endfunction

  task automatic set_fields(int op, int r1, int r2, int r3, int addr);
    in_opcode = 3'(op); in_reg1 = 5'(r1); in_reg2 = 5'(r2);
    in_reg3 = 5'(r3); in_addr = 16'(addr);
  endtask

  // One clock: check combinational outputs, advance model, cross edge, check registered outputs.
  task automatic cycle();
    bit exp_ready, acc, pop;
    #1;
    exp_ready = (q.size() < DEPTH) && !flush;
    pop       = (q.size() != 0) && out_ready;
    acc       = in_valid && exp_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("out_inst", out_inst, (q.size() != 0) ? q[0] : 64'd0);
    m_err_pulse = 0;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc && in_reg3 < 8) q.push_back(pack(in_opcode, in_reg1, in_reg2, in_reg3, in_addr));
    end
    if (acc && in_reg3 >= 8) begin
      m_err_pulse = 1;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    @(posedge clk);
    #1;
    chk("err_reg3", 64'(err_reg3), 64'(m_err_pulse));
    chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_inst", out_inst, 64'd0);
    chk("rst_err_reg3", 64'(err_reg3), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single word
    set_fields(1, 2, 3, 4, 16'h1234); in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    #1 chk("single_word", out_inst, 64'h0000_0000_221C_1234);
    cycle();
    chk("single_drain", 64'(count), 64'd0);

    // all-ones fields
    set_fields(7, 31, 31, 7, 16'hFFFF); in_valid = 1;
    cycle();
    in_valid = 0;
    #1 chk("all_ones", out_inst, 64'h0000_0000_FFFF_FFFF);
    cycle();

    // fill and backpressure
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      set_fields(2, i, i, i % 8, i); in_valid = 1;
      cycle();
    end
    cycle();
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    in_valid = 0;
    for (int i = 0; i < 8; i++) cycle();
    chk("fill_drained", 64'(count), 64'd0);

    // rejection
    set_fields(3, 1, 1, 9, 16'h55AA); in_valid = 1;
    cycle();
    chk("rej_pulse", 64'(err_reg3), 64'd1);
    chk("rej_cnt", 64'(err_cnt), 64'd1);
    in_valid = 0;
    cycle();
    chk("rej_pulse_end", 64'(err_reg3), 64'd0);
    in_valid = 1;
    for (int i = 0; i < 300; i++) cycle();
    in_valid = 0;
    cycle();
    chk("rej_saturate", 64'(err_cnt), 64'd255);

    // flush with concurrent traffic
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_fields(4, i, 0, 1, 16'h100 + i); in_valid = 1;
      cycle();
    end
    chk("pre_flush", 64'(count), 64'd5);
    flush = 1; out_ready = 1;
    cycle();
    flush = 0; in_valid = 0;
    #1 chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_errcnt", 64'(err_cnt), 64'd255);
    cycle();

    // simultaneous push and pop at count 3
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_fields(5, i, 2, 3, 16'h200 + i); in_valid = 1;
      cycle();
    end
    out_ready = 1; set_fields(5, 9, 9, 2, 16'h2FF);
    cycle();
    chk("push_pop_count", 64'(count), 64'd3);
    in_valid = 0;
    for (int i = 0; i < 4; i++) cycle();

    // async reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_fields(6, i, 1, 2, 16'h300 + i); in_valid = 1;
      cycle();
    end
    in_valid = 0;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_errcnt", 64'(err_cnt), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    q.delete(); m_err_cnt = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    set_fields(2, 7, 6, 5, 16'hBEEF); in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    #1 chk("arst_first_word", out_inst, pack(2, 7, 6, 5, 16'hBEEF));
    cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_fields($urandom_range(7), $urandom_range(31), $urandom_range(31),
                 ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(7),
                 $urandom_range(16'hFFFF));
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(60) == 0);
      cycle();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
